// File: rtl/motor_act_pkg.sv
// Shared definitions for the streaming motor-network activation block:
// mode encodings, default fixed-point format and small helpers.
package motor_act_pkg;

   typedef enum logic [1:0] {
      ACT_RELU   = 2'd0,
      ACT_LEAKY  = 2'd1,
      ACT_CLIP   = 2'd2,
      ACT_BYPASS = 2'd3
   } act_mode_e;

   localparam int ACT_W    = 16;
   localparam int ACT_I    = 7;
   localparam int ACT_F    = ACT_W - ACT_I;
   localparam int CLIP_6_0 = 6 << ACT_F;

   // Saturating 16-bit increment used by the clip event counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = 16'hFFFF;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/motor_act_lane.sv
// One channel of the output-stage activation: a purely combinational
// function of the captured value, its sign/compare bits and the beat mode.
module motor_act_lane
   import motor_act_pkg::*;
#(
   parameter int W           = ACT_W,
   parameter int ALPHA_SHIFT = 3,
   parameter int CLIP        = CLIP_6_0
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   input  logic         gt,
   input  logic [1:0]   mode,
   output logic [W-1:0] y,
   output logic         clip
);

   localparam logic [W-1:0] CLIP_V = W'(CLIP);

   logic [W-1:0] w_leaky;

   // Arithmetic shift floors toward -inf, so small negatives stay at -1
   assign w_leaky = $signed(x) >>> ALPHA_SHIFT;

   // Mode-selected activation for this channel
   always_comb begin
      y    = '0;
      clip = 1'b0;
      case (act_mode_e'(mode))
         ACT_RELU: begin
            if (neg) begin
               y = '0;
            end else begin
               y = x;
            end
         end
         ACT_LEAKY: begin
            if (neg) begin
               y = w_leaky;
            end else begin
               y = x;
            end
         end
         ACT_CLIP: begin
            if (neg) begin
               y = '0;
            end else if (gt) begin
               y    = CLIP_V;
               clip = 1'b1;
            end else begin
               y = x;
            end
         end
         ACT_BYPASS: begin
            y = x;
         end
         default: begin
            y    = '0;
            clip = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/motor_act_stream.sv
// Two-stage valid/ready activation pipeline for N fixed-point channels per beat.
// S1 captures data, mode and compare bits; S2 holds the activated result.
module motor_act_stream
   import motor_act_pkg::*;
#(
   parameter int W           = ACT_W,
   parameter int I           = ACT_I,
   parameter int N           = 4,
   parameter int ALPHA_SHIFT = 3,
   parameter int CLIP        = 6 << (W - I)
) (
   input  logic           ap_clk,
   input  logic           ap_rst_n,
   input  logic [1:0]     mode,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] out_data,
   output logic [N-1:0]   out_clip,
   output logic [15:0]    clip_beats
);

   localparam logic signed [W-1:0] CLIP_S = W'(CLIP);

   logic           r_v1;
   logic           r_v2;
   logic [N*W-1:0] r_s1_x;
   logic [N-1:0]   r_s1_neg;
   logic [N-1:0]   r_s1_gt;
   logic [1:0]     r_s1_mode;
   logic [N*W-1:0] r_out_data;
   logic [N-1:0]   r_out_clip;
   logic [15:0]    r_clip_beats;

   logic           w_adv2;
   logic           w_accept;
   logic [N-1:0]   w_in_neg;
   logic [N-1:0]   w_in_gt;
   logic [N*W-1:0] w_y;
   logic [N-1:0]   w_clip;

   // in_ready is combinational from out_ready so a full pipe still streams
   assign w_adv2   = ~r_v2 | out_ready;
   assign in_ready = ~r_v1 | w_adv2;
   assign w_accept = in_valid & in_ready;

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign w_in_neg[k] = in_data[k*W + W - 1];
      assign w_in_gt[k]  = $signed(in_data[k*W +: W]) > CLIP_S;

      motor_act_lane #(
         .W           (W),
         .ALPHA_SHIFT (ALPHA_SHIFT),
         .CLIP        (CLIP)
      ) u_lane (
         .x    (r_s1_x[k*W +: W]),
         .neg  (r_s1_neg[k]),
         .gt   (r_s1_gt[k]),
         .mode (r_s1_mode),
         .y    (w_y[k*W +: W]),
         .clip (w_clip[k])
      );
   end

   // Stage 1: capture the accepted beat together with its mode
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v1      <= 1'b0;
         r_s1_x    <= '0;
         r_s1_neg  <= '0;
         r_s1_gt   <= '0;
         r_s1_mode <= 2'd0;
      end else begin
         r_v1 <= w_accept | (r_v1 & ~w_adv2);
         if (w_accept) begin
            r_s1_x    <= in_data;
            r_s1_neg  <= w_in_neg;
            r_s1_gt   <= w_in_gt;
            r_s1_mode <= mode;
         end
      end
   end

   // Stage 2: activated output, held while downstream stalls
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v2       <= 1'b0;
         r_out_data <= '0;
         r_out_clip <= '0;
      end else begin
         if (w_adv2) begin
            r_v2       <= r_v1;
            r_out_data <= w_y;
            r_out_clip <= w_clip & {N{r_v1}};
         end
      end
   end

   // Count delivered beats that carried at least one clipped channel
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_clip_beats <= 16'd0;
      end else begin
         if (r_v2 & out_ready & (|r_out_clip)) begin
            r_clip_beats <= sat_inc16(r_clip_beats);
         end
      end
   end

   assign out_valid  = r_v2;
   assign out_data   = r_out_data;
   assign out_clip   = r_out_clip;
   assign clip_beats = r_clip_beats;

endmodule

// File: tb/tb_motor_act_stream.sv
// Self-checking bench for motor_act_stream: directed mode vectors, reset,
// backpressure streaming, randomized streaming and counter saturation.
module tb_motor_act_stream;

   localparam int W     = 16;
   localparam int N     = 4;
   localparam int AS    = 3;
   localparam int CLIPV = 3072;

   typedef struct packed {
      logic [N-1:0]   clip;
      logic [N*W-1:0] data;
   } beat_t;

   logic           ap_clk = 1'b0;
   logic           ap_rst_n = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N*W-1:0] in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_clip;
   logic [15:0]    clip_beats;

   int   n_checks = 0;
   int   n_fail = 0;
   logic lat_valid;
   int   cb_model = 0;

   always #5 ap_clk = ~ap_clk;

   motor_act_stream #(.W(W), .I(7), .N(N), .ALPHA_SHIFT(AS), .CLIP(CLIPV)) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_clip   (out_clip),
      .clip_beats (clip_beats)
   );

   // Reference activation on integers: returns {clip, y}
   function automatic logic [W:0] act_ch(input logic [1:0] m, input logic [W-1:0] raw);
      int x;
      int y;
      logic c;
      x = $signed(raw);
      c = 1'b0;
      case (m)
         2'd0: y = (x > 0) ? x : 0;
         2'd1: y = (x < 0) ? ((x - ((1 << AS) - 1)) / (1 << AS)) : x;
         2'd2: begin
            if (x < 0) y = 0;
            else if (x > CLIPV) begin y = CLIPV; c = 1'b1; end
            else y = x;
         end
         default: y = x;
      endcase
      return {c, y[W-1:0]};
   endfunction

   function automatic beat_t model_beat(input logic [1:0] m, input logic [N*W-1:0] d);
      beat_t b;
      logic [W:0] r;
      for (int k = 0; k < N; k++) begin
         r = act_ch(m, d[k*W +: W]);
         b.data[k*W +: W] = r[W-1:0];
         b.clip[k] = r[W];
      end
      return b;
   endfunction

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0: v = 16'h8000;
         1: v = 16'h7FFF;
         2: v = 16'(CLIPV - 1 + $urandom_range(0, 2));
         3: v = 16'h0000;
         4: v = 16'hFFFF;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   // Drive one beat into an empty pipe; returns once its result is visible
   task automatic send_one(input logic [1:0] m, input logic [N*W-1:0] d);
      @(negedge ap_clk);
      mode = m; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge ap_clk);
      in_valid = 1'b0;
      #1 lat_valid = out_valid;
      @(negedge ap_clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if (clip_beats !== 16'd0) begin n_fail++; $display("FAIL reset_clip_beats: got %h want 0", clip_beats); end
      @(negedge ap_clk); ap_rst_n = 1'b1;
      cb_model = 0;
      send_one(2'd2, {16'h0000, 16'h0000, 16'h0000, 16'h0C01});
      @(negedge ap_clk); cb_model = 1;
      #1;
      n_checks++; if (clip_beats !== 16'(cb_model)) begin n_fail++; $display("FAIL pre_reset_clip_beats: got %h want %h", clip_beats, 16'(cb_model)); end
      // fill both stages while downstream stalls
      out_ready = 1'b0; in_valid = 1'b1; mode = 2'd3; in_data = {4{16'h1234}};
      @(negedge ap_clk); in_data = {4{16'h5678}};
      @(negedge ap_clk); in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %0b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %0b want 1", out_valid); end
      ap_rst_n = 1'b0;
      #1;
      cb_model = 0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
      n_checks++; if (out_clip !== '0) begin n_fail++; $display("FAIL midrst_out_clip: got %b want 0", out_clip); end
      n_checks++; if (clip_beats !== 16'd0) begin n_fail++; $display("FAIL midrst_clip_beats: got %h want 0", clip_beats); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
      @(negedge ap_clk); ap_rst_n = 1'b1; out_ready = 1'b1;
      @(negedge ap_clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %0b want 0", out_valid); end
      send_one(2'd3, {16'h0004, 16'h0003, 16'h0002, 16'hABCD});
      n_checks++; if (lat_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %0b want 0", lat_valid); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %0b want 1", out_valid); end
      n_checks++; if (out_data !== {16'h0004, 16'h0003, 16'h0002, 16'hABCD}) begin n_fail++; $display("FAIL latency_data: got %h want %h", out_data, {16'h0004, 16'h0003, 16'h0002, 16'hABCD}); end
   endtask

   task automatic test_relu();
      send_one(2'd0, {16'h8000, 16'h0000, 16'hFF00, 16'h0100});
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL relu_valid: got %0b want 1", out_valid); end
      n_checks++; if (out_data !== {16'h0000, 16'h0000, 16'h0000, 16'h0100}) begin n_fail++; $display("FAIL relu_data: got %h want %h", out_data, {16'h0000, 16'h0000, 16'h0000, 16'h0100}); end
      n_checks++; if (out_clip !== 4'b0000) begin n_fail++; $display("FAIL relu_clip: got %b want 0000", out_clip); end
   endtask

   task automatic test_leaky();
      send_one(2'd1, {16'h8000, 16'h0040, 16'hFFFF, 16'hFF00});
      n_checks++; if (out_data !== {16'hF000, 16'h0040, 16'hFFFF, 16'hFFE0}) begin n_fail++; $display("FAIL leaky_data: got %h want %h", out_data, {16'hF000, 16'h0040, 16'hFFFF, 16'hFFE0}); end
      n_checks++; if (out_clip !== 4'b0000) begin n_fail++; $display("FAIL leaky_clip: got %b want 0000", out_clip); end
   endtask

   task automatic test_clip();
      send_one(2'd2, {16'h0200, 16'hFFFF, 16'h0C00, 16'h0C01});
      n_checks++; if (out_data !== {16'h0200, 16'h0000, 16'h0C00, 16'h0C00}) begin n_fail++; $display("FAIL clip_data: got %h want %h", out_data, {16'h0200, 16'h0000, 16'h0C00, 16'h0C00}); end
      n_checks++; if (out_clip !== 4'b0001) begin n_fail++; $display("FAIL clip_flags: got %b want 0001", out_clip); end
      n_checks++; if (clip_beats !== 16'(cb_model)) begin n_fail++; $display("FAIL clip_cnt_before: got %h want %h", clip_beats, 16'(cb_model)); end
      @(negedge ap_clk); cb_model++;
      #1;
      n_checks++; if (clip_beats !== 16'(cb_model)) begin n_fail++; $display("FAIL clip_cnt_after: got %h want %h", clip_beats, 16'(cb_model)); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clip_drained: got %0b want 0", out_valid); end
   endtask

   // Scoreboarded stream; directed = alternating modes with a 3-cycle stall
   task automatic test_stream(input int nbeats, input bit directed);
      beat_t          q[$];
      beat_t          e;
      int             sent = 0;
      int             got = 0;
      int             cyc = 0;
      bit             saw_stall = 1'b0;
      bit             prev_hold = 1'b0;
      logic [N*W-1:0] prev_data = '0;
      logic [N-1:0]   prev_clip = '0;
      logic [N*W-1:0] d;
      logic [1:0]     m;
      logic           exp_rdy;
      while (got < nbeats && cyc < 4000) begin
         @(negedge ap_clk);
         for (int k = 0; k < N; k++) d[k*W +: W] = pick_val();
         if (directed) begin
            in_valid  = (sent < nbeats);
            out_ready = !(cyc >= 4 && cyc < 7);
            m         = 2'(sent % 4);
         end else begin
            in_valid  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            m         = 2'($urandom_range(0, 3));
         end
         mode = m; in_data = d;
         #1;
         exp_rdy = !(q.size() == 2 && !out_ready);
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stream_in_ready cyc %0d: got %0b want %0b", cyc, in_ready, exp_rdy); end
         if (prev_hold) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_clip !== prev_clip) begin n_fail++; $display("FAIL stream_hold cyc %0d: got %0b/%h/%b want 1/%h/%b", cyc, out_valid, out_data, out_clip, prev_data, prev_clip); end
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL stream_spurious cyc %0d: got beat %h want none", cyc, out_data);
            end else begin
               e = q.pop_front();
               n_checks++; if (out_data !== e.data || out_clip !== e.clip) begin n_fail++; $display("FAIL stream_beat %0d: got %h/%b want %h/%b", got, out_data, out_clip, e.data, e.clip); end
               got++;
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_clip = out_clip;
         if (!in_ready) saw_stall = 1'b1;
         if (in_valid && in_ready) begin
            q.push_back(model_beat(m, d));
            sent++;
         end
         cyc++;
      end
      n_checks++; if (got != nbeats) begin n_fail++; $display("FAIL stream_count: got %0d want %0d beats", got, nbeats); end
      if (directed) begin
         n_checks++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL stream_backpressure: got stall=%0b want 1", saw_stall); end
      end
      @(negedge ap_clk); in_valid = 1'b0; out_ready = 1'b1;
      @(negedge ap_clk);
   endtask

   task automatic test_saturation();
      int exp_cb = 0;
      @(negedge ap_clk); ap_rst_n = 1'b0;
      @(negedge ap_clk); ap_rst_n = 1'b1;
      for (int i = 0; i < 65545; i++) begin
         @(negedge ap_clk);
         mode = 2'd2; in_data = {N{16'h7FFF}}; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         if ((i % 8192) == 0 || i > 65535) begin
            n_checks++; if (clip_beats !== 16'(exp_cb)) begin n_fail++; $display("FAIL sat_count i=%0d: got %h want %h", i, clip_beats, 16'(exp_cb)); end
         end
         if (out_valid && out_ready) exp_cb = (exp_cb >= 65535) ? 65535 : exp_cb + 1;
      end
      @(negedge ap_clk); in_valid = 1'b0;
      #1;
      n_checks++; if (clip_beats !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final: got %h want ffff", clip_beats); end
   endtask

   initial begin
      test_reset();
      test_relu();
      test_leaky();
      test_clip();
      test_stream(8, 1'b1);
      test_stream(300, 1'b0);
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
